// File: rtl/nibble_pkg.sv
// Shared definitions for the nibble link (serializer and deserializer sides).
package nibble_pkg;

   localparam int NIB_W  = 4;
   localparam int BYTE_W = 8;

   // IDLE: waiting for the first nibble of a byte; HALF: one nibble held
   typedef enum logic {
      IDLE = 1'b0,
      HALF = 1'b1
   } state_t;

endpackage : nibble_pkg

// File: rtl/nibble_sync_fifo.sv
// Single-clock byte FIFO used as the output buffer of the nibble deserializer.
// The head entry is driven straight from the storage flops, so a pushed byte
// becomes visible the cycle after the push. There is no push-to-output bypass.
// Push and pop in the same cycle are allowed, including when the FIFO is full.
module nibble_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             do_push;
   logic             do_pop;

   // A pop on an empty FIFO is ignored. A push is accepted when there is
   // space, or when a pop in the same cycle frees a slot.
   assign do_pop  = pop && (count_reg != '0);
   assign do_push = push && ((count_reg != FULL_CNT) || do_pop);

   assign full  = (count_reg == FULL_CNT);
   assign empty = (count_reg == '0);
   assign dout  = mem[rd_ptr_reg];

   // Storage write. Contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   // Pointer and occupancy bookkeeping. DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule : nibble_sync_fifo

// File: rtl/nibble_deserializer.sv
// Nibble-to-byte deserializer. It pairs consecutive nibbles into bytes and
// buffers them in a small FIFO behind a valid/ready byte interface.
// Optional feature macro: NIBBLE_DESER_CNT_EN adds the CNT_W parameter and the
// byte_count port. byte_count counts every byte pushed into the FIFO.
module nibble_deserializer
   import nibble_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
`ifdef NIBBLE_DESER_CNT_EN
   ,
   parameter int CNT_W      = 16
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NIB_W-1:0]  nib_in,
   input  logic              nib_valid,
   output logic              nib_ready,
   input  logic              swap_en,
   input  logic              flush,
   output logic [BYTE_W-1:0] byte_out,
   output logic              byte_valid,
   input  logic              byte_ready,
`ifdef NIBBLE_DESER_CNT_EN
   output logic [CNT_W-1:0]  byte_count,
`endif
   output logic              frag_err
);

   state_t             state_reg;
   logic [NIB_W-1:0]   hold_reg;
   logic               swap_reg;
   logic               frag_err_reg;

   logic               nib_fire;
   logic               fifo_push;
   logic               fifo_full;
   logic               fifo_empty;
   logic [BYTE_W-1:0]  byte_next;

   // Nibble acceptance. The first nibble is always accepted. The second nibble
   // is accepted only when the FIFO can take the byte, which includes the case
   // where the consumer frees a slot in the same cycle. Reset and flush block
   // all transfers.
   always_comb begin
      nib_ready = 1'b0;
      if (!rst && !flush) begin
         if (state_reg == IDLE) begin
            nib_ready = 1'b1;
         end else begin
            nib_ready = !fifo_full || byte_ready;
         end
      end
   end

   assign nib_fire  = nib_valid && nib_ready;
   assign fifo_push = nib_fire && (state_reg == HALF);

   // The latched swap value picks the nibble order. The live swap_en value is ignored here.
   assign byte_next = swap_reg ? {nib_in, hold_reg} : {hold_reg, nib_in};

   // Pairing FSM with the held nibble, the latched order, and the fragment-error pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         hold_reg     <= '0;
         swap_reg     <= 1'b0;
         frag_err_reg <= 1'b0;
      end else begin
         frag_err_reg <= flush && (state_reg == HALF);
         case (state_reg)
            IDLE: begin
               if (nib_fire) begin
                  hold_reg  <= nib_in;
                  swap_reg  <= swap_en;
                  state_reg <= HALF;
               end
            end
            HALF: begin
               if (flush || nib_fire) begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign frag_err = frag_err_reg;

   nibble_sync_fifo #(
      .WIDTH (BYTE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .din   (byte_next),
      .full  (fifo_full),
      .pop   (byte_ready),
      .dout  (byte_out),
      .empty (fifo_empty)
   );

   assign byte_valid = !fifo_empty;

`ifdef NIBBLE_DESER_CNT_EN
   logic [CNT_W-1:0] count_reg;

   // Count of pushed bytes. It wraps at 2^CNT_W, and a flushed fragment never reaches the push.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
      end else if (fifo_push) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign byte_count = count_reg;
`endif

endmodule : nibble_deserializer

// File: tb/tb_nibble_deserializer.sv
// Directed testbench for nibble_deserializer. The expected values are worked out by hand.
// Inputs are driven and outputs are sampled 1 time unit after each rising edge.
module tb_nibble_deserializer;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] nib_in;
   logic       nib_valid;
   logic       nib_ready;
   logic       swap_en;
   logic       flush;
   logic [7:0] byte_out;
   logic       byte_valid;
   logic       byte_ready;
   logic       frag_err;
`ifdef NIBBLE_DESER_CNT_EN
   logic [3:0] byte_count;
`endif

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   nibble_deserializer #(
      .FIFO_DEPTH (4)
`ifdef NIBBLE_DESER_CNT_EN
      ,
      .CNT_W      (4)
`endif
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .nib_in     (nib_in),
      .nib_valid  (nib_valid),
      .nib_ready  (nib_ready),
      .swap_en    (swap_en),
      .flush      (flush),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
`ifdef NIBBLE_DESER_CNT_EN
      .byte_count (byte_count),
`endif
      .frag_err   (frag_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one nibble and hold it until it is accepted. The wait is bounded.
   task automatic send_nib(input logic [3:0] n, input logic sw);
      int waited;
      waited    = 0;
      nib_in    = n;
      swap_en   = sw;
      nib_valid = 1'b1;
      #1;
      while (!nib_ready && waited < 50) begin
         step();
         waited++;
      end
      if (!nib_ready) check("nib_ready_timeout", 32'(nib_ready), 32'd1);
      step();
      nib_valid = 1'b0;
   endtask

   // Pop the head byte for one cycle.
   task automatic pop_one();
      byte_ready = 1'b1;
      step();
      byte_ready = 1'b0;
   endtask

   logic [7:0] drain_exp [4];

   initial begin
      rst = 1'b1; nib_in = '0; nib_valid = 1'b0; swap_en = 1'b0;
      flush = 1'b0; byte_ready = 1'b0;
      step();
      step();
      // Reset state
      check("rst_nib_ready", 32'(nib_ready), 32'd0);
      check("rst_byte_valid", 32'(byte_valid), 32'd0);
      check("rst_frag_err", 32'(frag_err), 32'd0);
      rst = 1'b0;
      #1;
      check("idle_nib_ready", 32'(nib_ready), 32'd1);

      // Test 1: upper nibble first. byte_valid rises on the third cycle.
      byte_ready = 1'b1;
      send_nib(4'hA, 1'b0);
      check("t1_no_early_valid", 32'(byte_valid), 32'd0);
      send_nib(4'h5, 1'b0);
      check("t1_valid", 32'(byte_valid), 32'd1);
      check("t1_byte", 32'(byte_out), 32'hA5);
      step();
      check("t1_popped", 32'(byte_valid), 32'd0);
      byte_ready = 1'b0;

      // Test 2: lower nibble first. Toggling swap_en on the second nibble has no effect.
      send_nib(4'hA, 1'b1);
      send_nib(4'h5, 1'b0);
      check("t2_byte", 32'(byte_out), 32'h5A);
      pop_one();
      check("t2_popped", 32'(byte_valid), 32'd0);

      // Test 3: nine nibbles with the consumer stalled.
      for (int i = 0; i < 9; i++) send_nib(4'(i), 1'b0);
      nib_in = 4'h9; nib_valid = 1'b1; swap_en = 1'b0;
      #1;
      check("t3_full_stall", 32'(nib_ready), 32'd0);
      step();
      check("t3_full_stall2", 32'(nib_ready), 32'd0);
      byte_ready = 1'b1;
      #1;
      check("t3_ready_on_pop", 32'(nib_ready), 32'd1);
      check("t3_head", 32'(byte_out), 32'h01);
      step();
      nib_valid = 1'b0;
      drain_exp[0] = 8'h23; drain_exp[1] = 8'h45; drain_exp[2] = 8'h67; drain_exp[3] = 8'h89;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t3_drain_valid%0d", i), 32'(byte_valid), 32'd1);
         check($sformatf("t3_drain_byte%0d", i), 32'(byte_out), 32'(drain_exp[i]));
         step();
      end
      check("t3_empty", 32'(byte_valid), 32'd0);
      byte_ready = 1'b0;

      // Flush while IDLE does nothing.
      flush = 1'b1;
      #1;
      check("idle_flush_ready", 32'(nib_ready), 32'd0);
      step();
      flush = 1'b0;
      check("idle_flush_no_pulse", 32'(frag_err), 32'd0);

      // Test 4: a half byte is flushed, and the next pair assembles cleanly.
      send_nib(4'h3, 1'b0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("t4_frag_err", 32'(frag_err), 32'd1);
      check("t4_no_push", 32'(byte_valid), 32'd0);
      step();
      check("t4_frag_err_once", 32'(frag_err), 32'd0);
      send_nib(4'h1, 1'b0);
      send_nib(4'h2, 1'b0);
      check("t4_byte", 32'(byte_out), 32'h12);
      pop_one();

      // Test 5: reset in HALF with two bytes queued.
      send_nib(4'h1, 1'b0); send_nib(4'h2, 1'b0);
      send_nib(4'h3, 1'b0); send_nib(4'h4, 1'b0);
      send_nib(4'h5, 1'b0);
      check("t5_queued", 32'(byte_valid), 32'd1);
      rst = 1'b1;
      step();
      check("t5_rst_valid", 32'(byte_valid), 32'd0);
      check("t5_rst_ready", 32'(nib_ready), 32'd0);
      rst = 1'b0;
      send_nib(4'hF, 1'b0);
      send_nib(4'h0, 1'b0);
      check("t5_byte", 32'(byte_out), 32'hF0);
      pop_one();

`ifdef NIBBLE_DESER_CNT_EN
      // Test 6: the counter wraps at 16 and skips flushed fragments.
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t6_cnt_reset", 32'(byte_count), 32'd0);
      byte_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         send_nib(4'h6, 1'b0);
         send_nib(4'h9, 1'b0);
         if (i == 8) begin
            send_nib(4'h7, 1'b0);
            flush = 1'b1;
            step();
            flush = 1'b0;
         end
      end
      step();
      check("t6_cnt_wrap", 32'(byte_count), 32'd1);
      byte_ready = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule : tb_nibble_deserializer
